// File: rtl/io_port_pkg.sv
// Shared constants for the memory-mapped input port block: word addresses
// within the block and the default board widths.
package io_port_pkg;
    localparam logic [1:0] IO_ADDR_SW  = 2'd0;
    localparam logic [1:0] IO_ADDR_KEY = 2'd1;
    localparam logic [1:0] IO_ADDR_EVT = 2'd2;

    localparam int SW_W  = 10;
    localparam int KEY_W = 3;
endpackage

// File: rtl/io_input_port_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a stability counter that
// only lets the debounced level change after DEBOUNCE_CYCLES agreeing samples.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic toggle
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             stable_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        toggle      = 1'b0;
        if (sync2_reg == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            stable_next = sync2_reg;
            cnt_next    = '0;
            toggle      = 1'b1;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg  <= RESET_VAL;
            sync2_reg  <= RESET_VAL;
            stable_reg <= RESET_VAL;
            cnt_reg    <= '0;
        end else begin
            sync1_reg  <= raw;
            sync2_reg  <= sync1_reg;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign stable = stable_reg;
endmodule

// File: rtl/io_input_port.sv
// Board switch/key input block: debounces every bit, latches key presses in
// sticky clear-on-read flags and serves them through a registered read port.
module io_input_port #(
    parameter int SW_W            = io_port_pkg::SW_W,
    parameter int KEY_W           = io_port_pkg::KEY_W,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [KEY_W-1:0] key_raw,
    output logic [SW_W-1:0]  sw_db,
    output logic [KEY_W-1:0] key_pressed,
    output logic [KEY_W-1:0] key_event,
    input  logic             rd_en,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data
);
    import io_port_pkg::*;

    logic [SW_W-1:0]  sw_toggle;
    logic [KEY_W-1:0] key_stable;
    logic [KEY_W-1:0] key_toggle;
    logic [KEY_W-1:0] press_set;
    logic [KEY_W-1:0] evt_clear;
    logic [KEY_W-1:0] event_reg;
    logic [KEY_W-1:0] event_next;
    logic [31:0]      rd_data_reg;
    logic [31:0]      rd_data_next;

    generate
        for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W),
                .RESET_VAL      (1'b0)
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .raw   (sw_raw[gi]),
                .stable(sw_db[gi]),
                .toggle(sw_toggle[gi])
            );
        end
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W),
                .RESET_VAL      (1'b1)
            ) u_db (
                .clk   (clk),
                .reset (reset),
                .raw   (key_raw[gi]),
                .stable(key_stable[gi]),
                .toggle(key_toggle[gi])
            );
        end
    endgenerate

    assign key_pressed = ~key_stable;
    // Keys are active-low: a toggle while still released is a press.
    assign press_set   = key_toggle & key_stable;

    always_comb begin
        rd_data_next = rd_data_reg;
        evt_clear    = '0;
        if (rd_en) begin
            case (rd_addr)
                IO_ADDR_SW:  rd_data_next = {{(32-SW_W){1'b0}}, sw_db};
                IO_ADDR_KEY: rd_data_next = {{(32-KEY_W){1'b0}}, key_pressed};
                IO_ADDR_EVT: begin
                    rd_data_next = {{(32-KEY_W){1'b0}}, event_reg};
                    evt_clear    = event_reg;
                end
                default:     rd_data_next = 32'b0;
            endcase
        end
        // Set after clear so a press coinciding with the read survives.
        event_next = (event_reg & ~evt_clear) | press_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            event_reg   <= event_next;
            rd_data_reg <= rd_data_next;
        end
    end

    assign key_event = event_reg;
    assign rd_data   = rd_data_reg;
endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with DEBOUNCE_CYCLES = 4: a run-length
// reference model is compared every cycle, plus hand-computed literal checks.
module tb_io_input_port;
    localparam int DB = 4;
    localparam logic [12:0] RST_RAW = {3'b111, 10'b0};

    logic        clk;
    logic        reset;
    logic [9:0]  sw_raw;
    logic [2:0]  key_raw;
    logic [9:0]  sw_db;
    logic [2:0]  key_pressed;
    logic [2:0]  key_event;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    io_input_port #(
        .SW_W(10), .KEY_W(3), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .key_raw(key_raw),
        .sw_db(sw_db), .key_pressed(key_pressed), .key_event(key_event),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: each bit flips once the level seen two edges ago has
    // disagreed with the debounced level for DB consecutive edges.
    logic [12:0] m_hist1, m_hist2, m_stable;
    logic [2:0]  m_event;
    logic [31:0] m_rd;
    int          m_run [13];
    bit          started = 0;

    always @(posedge clk) begin
        logic [12:0] prev;
        logic [2:0]  press;
        started = 1;
        if (reset) begin
            m_hist1 = RST_RAW;
            m_hist2 = RST_RAW;
            m_stable = RST_RAW;
            m_event = 3'b0;
            m_rd = 32'b0;
            for (int i = 0; i < 13; i++) m_run[i] = 0;
        end else begin
            prev = m_stable;
            if (rd_en) begin
                if (rd_addr == 2'd0)      m_rd = {22'b0, prev[9:0]};
                else if (rd_addr == 2'd1) m_rd = {29'b0, ~prev[12:10]};
                else if (rd_addr == 2'd2) m_rd = {29'b0, m_event};
                else                      m_rd = 32'b0;
            end
            for (int i = 0; i < 13; i++) begin
                if (m_hist2[i] != prev[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_stable[i] = m_hist2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            press = prev[12:10] & ~m_stable[12:10];
            if (rd_en && rd_addr == 2'd2) m_event = press;
            else                          m_event = m_event | press;
            m_hist2 = m_hist1;
            m_hist1 = {key_raw, sw_raw};
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_sw_db", {22'b0, sw_db}, {22'b0, m_stable[9:0]});
            check("cyc_key_pressed", {29'b0, key_pressed}, {29'b0, ~m_stable[12:10]});
            check("cyc_key_event", {29'b0, key_event}, {29'b0, m_event});
            check("cyc_rd_data", rd_data, m_rd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        $display("txn %s: got %h expected %h", name, act, exp);
        check(name, act, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sw_raw = 10'b1010101010; key_raw = 3'b011;
        rd_en = 1'b0; rd_addr = 2'd0;
        step(3);
        lit("reset_outputs", {sw_db, key_pressed, key_event, rd_data[0]}, 17'b0);
        reset = 1'b0;
        step(5);
        lit("reset_latency_early", {22'b0, sw_db}, 32'h0);
        step(1);
        lit("reset_sw_db", {22'b0, sw_db}, 32'h2AA);
        lit("reset_key_pressed", {29'b0, key_pressed}, 32'h4);
        rd_en = 1'b1; rd_addr = 2'd2; step(1); rd_en = 1'b0;
        lit("initial_evt_read", rd_data, 32'h4);
        lit("initial_evt_cleared", {29'b0, key_event}, 32'h0);

        sw_raw = 10'b1010101011; step(3);
        sw_raw = 10'b1010101010; step(8);
        lit("glitch_reject", {22'b0, sw_db}, 32'h2AA);
        sw_raw = 10'b1010101011; step(5);
        lit("pulse_not_yet", {22'b0, sw_db}, 32'h2AA);
        step(1);
        lit("pulse_edge6", {22'b0, sw_db}, 32'h2AB);
        sw_raw = 10'b1010101010; step(6);
        lit("pulse_fall", {22'b0, sw_db}, 32'h2AA);

        key_raw = 3'b101; step(6);
        lit("key2_pressed", {29'b0, key_pressed}, 32'h2);
        lit("key2_event", {29'b0, key_event}, 32'h2);
        rd_en = 1'b1; rd_addr = 2'd1; step(1);
        lit("read_key", rd_data, 32'h2);
        rd_addr = 2'd2; step(1);
        lit("read_evt", rd_data, 32'h2);
        lit("evt_cleared", {29'b0, key_event}, 32'h0);
        step(1);
        lit("read_evt_again", rd_data, 32'h0);
        rd_en = 1'b0;

        key_raw = 3'b111; step(6);
        lit("release_pressed", {29'b0, key_pressed}, 32'h0);
        lit("release_no_event", {29'b0, key_event}, 32'h0);

        key_raw = 3'b110; step(5);
        rd_en = 1'b1; rd_addr = 2'd2; step(1); rd_en = 1'b0;
        lit("collide_read", rd_data, 32'h0);
        lit("collide_event", {29'b0, key_event}, 32'h1);

        key_raw = 3'b010; step(4);
        reset = 1'b1; step(2);
        lit("midcount_reset", {29'b0, key_pressed}, 32'h0);
        reset = 1'b0; step(5);
        lit("post_reset_early", {29'b0, key_pressed}, 32'h0);
        step(1);
        lit("post_reset_pressed", {29'b0, key_pressed}, 32'h5);

        rd_en = 1'b1; rd_addr = 2'd3; step(1);
        lit("read_addr3", rd_data, 32'h0);
        rd_addr = 2'd0; step(1);
        lit("read_sw", rd_data, 32'h2AA);
        rd_en = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a); step(1);
            lit("hold_rd_data", rd_data, 32'h2AA);
        end
        lit("event_untouched", {29'b0, key_event}, 32'h5);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
